// File: rtl/encoder_pkg.sv
// Shared widths and FSM state type for the 16-to-4 request encoder.
// Build option: ENCODER_ROUND_ROBIN_EN selects round-robin arbitration.
package encoder_pkg;
  localparam int VEC_W = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;
endpackage

// File: rtl/request_encoder_16to4_if.sv
// Request/grant bundle between a requester and the 16-to-4 encoder.
// The master drives requests and ready; the slave presents grants.
interface request_encoder_16to4_if;
  import encoder_pkg::*;

  logic             enable;
  logic [VEC_W-1:0] req_in;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic [VEC_W-1:0] pending;

  modport master (
    output enable,
    output req_in,
    output out_ready,
    input  out_valid,
    input  out_index,
    input  pending
  );

  modport slave (
    input  enable,
    input  req_in,
    input  out_ready,
    output out_valid,
    output out_index,
    output pending
  );
endinterface

// File: rtl/pick_first_16.sv
// Combinational first-one finder over a 16-bit vector.
// The search begins at start and wraps from bit 15 to bit 0.
module pick_first_16
  import encoder_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] k;

  // Walk from start upward, keep the first set bit seen.
  always_comb begin
    found = 1'b0;
    index = '0;
    k     = '0;
    for (int i = 0; i < VEC_W; i++) begin
      k = start + IDX_W'(i);
      if (!found && vec[k]) begin
        found = 1'b1;
        index = k;
      end
    end
  end

endmodule

// File: rtl/request_encoder_16to4.sv
// Sticky 16-bit request register encoded to a 4-bit grant index.
// Build option: ENCODER_ROUND_ROBIN_EN selects round-robin arbitration.
module request_encoder_16to4
  import encoder_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  request_encoder_16to4_if.slave bus
);

  state_t           state;
  state_t           state_nx;
  logic [VEC_W-1:0] pend_q;
  logic [VEC_W-1:0] pend_nx;
  logic [VEC_W-1:0] clr_mask;
  logic [VEC_W-1:0] set_mask;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nx;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic             valid;
  logic             hs;

  assign valid         = (state == PRESENT);
  assign hs            = valid & bus.out_ready;
  assign bus.out_valid = valid;
  assign bus.out_index = idx_q;
  assign bus.pending   = pend_q;

  // A same-cycle set overrides the handshake clear.
  assign clr_mask = hs ? (VEC_W'(1) << idx_q) : '0;
  assign set_mask = bus.enable ? bus.req_in : '0;
  assign pend_nx  = (pend_q & ~clr_mask) | set_mask;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  // Remember the last granted index; search resumes just past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '1;
    end else if (hs) begin
      rr_ptr <= idx_q;
    end
  end

  assign start = rr_ptr + 1'b1;
`else
  assign start = '0;
`endif

  pick_first_16 u_pick (
    .vec   (pend_q),
    .start (start),
    .found (found),
    .index (pick)
  );

  // Pending register, grant index and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend_q <= '0;
      idx_q  <= '0;
    end else begin
      state  <= state_nx;
      pend_q <= pend_nx;
      idx_q  <= idx_nx;
    end
  end

  // Select in IDLE, hold the index in PRESENT until accepted.
  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = PRESENT;
          idx_nx   = pick;
        end
      end
      PRESENT: begin
        if (hs) state_nx = IDLE;
      end
    endcase
  end

endmodule
